// File: rtl/stream_min_max_pkg.sv
// Shared definitions for the stream_min_max reduction unit:
// state encoding and default widths.
package stream_min_max_pkg;

    localparam int DEFAULT_N       = 8;
    localparam int DEFAULT_MAX_LEN = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ACCUM = ST_ACCUM,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/signed_lt_cmp.sv
// Strict signed less-than over the full N bits, the same compare the ALU
// uses for set-less-than.
module signed_lt_cmp #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    assign lt = $signed(a) < $signed(b);

endmodule

// File: rtl/stream_min_max.sv
// Frame-wise running min/max tracker: consumes signed samples over a
// valid/ready stream and emits one registered record per frame.
module stream_min_max
    import stream_min_max_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N-1:0]                 in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N-1:0]                 min_val,
    output logic [N-1:0]                 max_val,
    output logic [$clog2(MAX_LEN)-1:0]   min_idx,
    output logic [$clog2(MAX_LEN)-1:0]   max_idx,
    output logic [$clog2(MAX_LEN):0]     count,
    output logic                         overflow
);

    localparam int IW = $clog2(MAX_LEN);

    // When the counter already holds MAX_LEN-1, the sample being accepted
    // is the one that fills the frame.
    localparam logic [IW:0] LAST_CNT = (IW + 1)'(MAX_LEN - 1);

    state_t state;
    state_t next_state;
    logic   accept;
    logic   new_min;
    logic   new_max;
    logic   frame_full;

    signed_lt_cmp #(.N(N)) u_min_cmp (
        .a  (in_data),
        .b  (min_val),
        .lt (new_min)
    );

    signed_lt_cmp #(.N(N)) u_max_cmp (
        .a  (max_val),
        .b  (in_data),
        .lt (new_max)
    );

    assign in_ready   = (state != DONE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign frame_full = (count == LAST_CNT);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && (in_last || frame_full)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Strict compares mean ties never move an index, so the earliest
    // occurrence is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            min_val  <= '0;
            max_val  <= '0;
            min_idx  <= '0;
            max_idx  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (accept) begin
                        min_val  <= in_data;
                        max_val  <= in_data;
                        min_idx  <= '0;
                        max_idx  <= '0;
                        count    <= (IW + 1)'(1);
                        overflow <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (new_min) begin
                            min_val <= in_data;
                            min_idx <= count[IW-1:0];
                        end
                        if (new_max) begin
                            max_val <= in_data;
                            max_idx <= count[IW-1:0];
                        end
                        count <= count + 1'b1;
                        if (!in_last && frame_full) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
